pokemon_match_ctrl: RTL and testbench
=====================================

# pokemon_match_ctrl

Match sequencer for the two-player Pokemon duel. It runs the title → countdown → fight → round-result loop and pulses a synchronous clear into the battle datapath before every round. It gates both players' move/shoot controls so they only reach the battle logic during a fight, and keeps a best-of-N score. It sits between the debounced button/switch layer and the battle logic; its scores and state drive the display overlay.

## Interface
Parameters:
- `CLEAR_CYCLES`, 4 — clk cycles `logic_clear` is held per round start
- `COUNT_STEPS`, 3 — countdown digits shown (3,2,1)
- `TICKS_PER_STEP`, 20 — ticks per countdown digit
- `ROUND_TICKS`, 600 — fight time limit in ticks (fits 10 bits)
- `END_TICKS`, 40 — ticks the round result is displayed
- `ROUNDS_TO_WIN`, 2 — round wins needed to take the match
- `MAX_ROUNDS`, 5 — round cap that guarantees termination on repeated draws

Ports (clock and reset first):
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; synchronous, active-low
- `tick`  in  1  one-clk-wide game-rate enable, same rate as the ball-move clock
- `start_btn`  in  1  single-cycle debounced pulse
- `char_alive`, `squir_alive`  in  1 each  alive flags from battle logic
- `health_char`, `health_squir`  in  7 each  health percent, 0–100
- `p1_ctrl`, `p2_ctrl`  in  3 each  raw {shoot, down, up}
- `p1_ctrl_g`, `p2_ctrl_g`  out  3 each  gated controls to battle logic
- `logic_clear`  out  1  synchronous clear to battle logic (HP, balls, shields, positions)
- `state`  out  3  IDLE=0, CLEAR=1, COUNTDOWN=2, FIGHT=3, ROUND_END=4, MATCH_OVER=5
- `countdown`  out  2  current countdown digit; 0 outside COUNTDOWN
- `round_timer`  out  10  remaining fight ticks
- `score_char`, `score_squir`  out  3 each  rounds won
- `round_winner`  out  2  00 none, 01 Charmander, 10 Squirtle, 11 draw
- `match_winner`  out  2  same encoding; valid in MATCH_OVER

## Operation
- **IDLE**: `start_btn` → CLEAR. Scores, round count and `match_winner` go to 0.
- **CLEAR**: `logic_clear`=1. A clk-cycle counter runs `CLEAR_CYCLES` cycles, then the block moves to COUNTDOWN with `countdown`=`COUNT_STEPS`.
- **COUNTDOWN**: counts `tick`s only. After `TICKS_PER_STEP` ticks, `countdown` decrements. When the step that began at 1 completes, the block moves to FIGHT with `round_timer`=`ROUND_TICKS` and `countdown`=0.
- **FIGHT**: controls are passed through. Each `tick` decrements `round_timer`. The end condition is evaluated every clk, in priority order:
  1. Both flags low → draw.
  2. `squir_alive`=0 → Charmander wins.
  3. `char_alive`=0 → Squirtle wins.
  4. `tick` while `round_timer`==1 → higher health wins; equal health → draw.
  
  On round end: set `round_winner`, increment the winner's score (none on draw), increment the round count, move to ROUND_END.
- **ROUND_END**: waits `END_TICKS` ticks. Then:
  - Either score == `ROUNDS_TO_WIN` → MATCH_OVER with that player as `match_winner`.
  - Otherwise, round count == `MAX_ROUNDS` → MATCH_OVER with the higher score wins; equal scores → 11.
  - Otherwise → CLEAR. `round_winner` is cleared on entry to CLEAR.
- **MATCH_OVER**: outputs hold. `start_btn` → CLEAR with scores, round count and winners zeroed.
- `start_btn` is ignored in CLEAR, COUNTDOWN, FIGHT and ROUND_END.
- Gated controls are 3'b000 in every state except FIGHT.
- Scores saturate at `ROUNDS_TO_WIN`. `round_timer` never wraps below 0.

## Timing
- All outputs are registered.
- Reset: state IDLE, `logic_clear` 0, gated controls 0, `countdown` 0, `round_timer` 0, scores 0, `round_winner` 0, `match_winner` 0.
- `reset_n` low mid-round returns to IDLE on the next clk, regardless of state.
- State changes one clk after the triggering input sample.
- `logic_clear` is high for exactly `CLEAR_CYCLES` consecutive clks per round.
- `p*_ctrl_g` = `p*_ctrl` delayed one clk. It is forced to 0 from the first clk after leaving FIGHT.
- Alive flags are ignored outside FIGHT. Stale low flags seen during CLEAR do not end the next round.
- A `tick` coinciding with a death resolves as the death, via the priority order above.

## Structure
- Shared package `pokemon_pkg`: state enum, winner encoding (NONE/CHAR/SQUIR/DRAW), `MAX_HP`-derived health width.
- Sub-module `tick_counter`: a loadable down-counter advanced by `tick`, with a done flag. It is instantiated for the countdown step, fight timer and round-end hold.

## Test plan
- Reset then `start_btn` → `logic_clear` high 4 clks; `countdown` steps 3,2,1 every 20 ticks; FIGHT entered; `p1_ctrl`=3'b100 appears on `p1_ctrl_g` one clk later.
- In FIGHT, drop `squir_alive` → `round_winner`=01, `score_char`=1, controls forced 0. After 40 ticks → CLEAR.
- Drive both alive flags low in the same clk → `round_winner`=11, no score change.
- Let `round_timer` expire with `health_char`=60, `health_squir`=80 → Squirtle wins; with 40/40 → draw.
- Charmander wins twice → MATCH_OVER, `match_winner`=01. `start_btn` → scores 0, CLEAR.
- Five consecutive draws → MATCH_OVER, `match_winner`=11. `reset_n` low during FIGHT → IDLE and all outputs at reset values next clk.

Source files
------------

// File: rtl/pokemon_pkg.sv
// Shared definitions for the Pokemon duel match sequencer: state and
// winner encodings, datapath widths and the health-comparison helper.
package pokemon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_COUNTDOWN  = 3'd2,
        ST_FIGHT      = 3'd3,
        ST_ROUND_END  = 3'd4,
        ST_MATCH_OVER = 3'd5
    } match_state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_CHAR  = 2'b01,
        WIN_SQUIR = 2'b10,
        WIN_DRAW  = 2'b11
    } winner_t;

    localparam int MAX_HP  = 100;
    localparam int HP_W    = $clog2(MAX_HP + 1);
    localparam int TIMER_W = 10;
    localparam int SCORE_W = 3;

    // Timeout verdict: the healthier player takes the round, a tie is a draw.
    function automatic winner_t health_winner(input logic [HP_W-1:0] hp_char,
                                              input logic [HP_W-1:0] hp_squir);
        if (hp_char > hp_squir) begin
            return WIN_CHAR;
        end
        if (hp_char < hp_squir) begin
            return WIN_SQUIR;
        end
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter advanced by the game-rate tick. done fires on the
// tick that takes the count from 1 to 0, so a load of N gives N ticks.
module tick_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             run,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    // Load has priority; otherwise count down on ticks while running, holding at 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (run && tick && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign done  = run && tick && (count_reg == WIDTH'(1));

endmodule

// File: rtl/pokemon_match_ctrl.sv
// Match sequencer: title -> clear -> countdown -> fight -> round result loop,
// control gating for both players and best-of-N scoring.
module pokemon_match_ctrl
    import pokemon_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 4,
    parameter int COUNT_STEPS    = 3,
    parameter int TICKS_PER_STEP = 20,
    parameter int ROUND_TICKS    = 600,
    parameter int END_TICKS      = 40,
    parameter int ROUNDS_TO_WIN  = 2,
    parameter int MAX_ROUNDS     = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       char_alive,
    input  logic       squir_alive,
    input  logic [6:0] health_char,
    input  logic [6:0] health_squir,
    input  logic [2:0] p1_ctrl,
    input  logic [2:0] p2_ctrl,
    output logic [2:0] p1_ctrl_g,
    output logic [2:0] p2_ctrl_g,
    output logic       logic_clear,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [9:0] round_timer,
    output logic [2:0] score_char,
    output logic [2:0] score_squir,
    output logic [1:0] round_winner,
    output logic [1:0] match_winner
);

    localparam int CLR_W   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int NUM_TC  = 3;
    localparam int TC_STEP = 0;   // countdown digit duration
    localparam int TC_FGT  = 1;   // fight time limit, also the visible round_timer
    localparam int TC_HOLD = 2;   // round-result display hold

    match_state_t state_reg, state_next;
    winner_t      fight_result, match_result;

    logic [CLR_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic               logic_clear_reg, logic_clear_next;
    logic [2:0]         p1_ctrl_g_reg, p1_ctrl_g_next;
    logic [2:0]         p2_ctrl_g_reg, p2_ctrl_g_next;
    logic [1:0]         countdown_reg, countdown_next;
    logic [SCORE_W-1:0] score_char_reg, score_char_next;
    logic [SCORE_W-1:0] score_squir_reg, score_squir_next;
    logic [SCORE_W-1:0] round_cnt_reg, round_cnt_next;
    winner_t            round_winner_reg, round_winner_next;
    winner_t            match_winner_reg, match_winner_next;

    logic [NUM_TC-1:0]              tc_load, tc_run, tc_done;
    logic [NUM_TC-1:0][TIMER_W-1:0] tc_value, tc_count;

    assign tc_value[TC_STEP] = TIMER_W'(TICKS_PER_STEP);
    assign tc_value[TC_FGT]  = TIMER_W'(ROUND_TICKS);
    assign tc_value[TC_HOLD] = TIMER_W'(END_TICKS);

    assign tc_run[TC_STEP] = (state_reg == ST_COUNTDOWN);
    assign tc_run[TC_FGT]  = (state_reg == ST_FIGHT);
    assign tc_run[TC_HOLD] = (state_reg == ST_ROUND_END);

    // The step timer also reloads between digits, except after the last one.
    assign tc_load[TC_STEP] = ((state_reg != ST_COUNTDOWN) && (state_next == ST_COUNTDOWN))
                           || (tc_done[TC_STEP] && (countdown_reg != 2'd1));
    assign tc_load[TC_FGT]  = (state_reg != ST_FIGHT) && (state_next == ST_FIGHT);
    assign tc_load[TC_HOLD] = (state_reg != ST_ROUND_END) && (state_next == ST_ROUND_END);

    generate
        for (genvar gi = 0; gi < NUM_TC; gi++) begin : g_tc
            tick_counter #(.WIDTH(TIMER_W)) u_tick_counter (
                .clk        (clk),
                .reset_n    (reset_n),
                .load       (tc_load[gi]),
                .load_value (tc_value[gi]),
                .run        (tc_run[gi]),
                .tick       (tick),
                .count      (tc_count[gi]),
                .done       (tc_done[gi])
            );
        end
    endgenerate

    // The step and hold timers are only observed through their done flags.
    logic unused_counts;
    assign unused_counts = ^{tc_count[TC_STEP], tc_count[TC_HOLD]};

    // Round verdict, in priority order; deaths outrank a coinciding timeout.
    always_comb begin
        fight_result = WIN_NONE;
        if (state_reg == ST_FIGHT) begin
            if (!char_alive && !squir_alive) begin
                fight_result = WIN_DRAW;
            end else if (!squir_alive) begin
                fight_result = WIN_CHAR;
            end else if (!char_alive) begin
                fight_result = WIN_SQUIR;
            end else if (tc_done[TC_FGT]) begin
                fight_result = health_winner(health_char, health_squir);
            end
        end
    end

    // Match verdict from the already-updated scores and round count.
    always_comb begin
        match_result = WIN_NONE;
        if (score_char_reg == SCORE_W'(ROUNDS_TO_WIN)) begin
            match_result = WIN_CHAR;
        end else if (score_squir_reg == SCORE_W'(ROUNDS_TO_WIN)) begin
            match_result = WIN_SQUIR;
        end else if (round_cnt_reg == SCORE_W'(MAX_ROUNDS)) begin
            if (score_char_reg > score_squir_reg) begin
                match_result = WIN_CHAR;
            end else if (score_char_reg < score_squir_reg) begin
                match_result = WIN_SQUIR;
            end else begin
                match_result = WIN_DRAW;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start_btn) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_cnt_reg == CLR_W'(CLEAR_CYCLES - 1)) state_next = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (tc_done[TC_STEP] && (countdown_reg == 2'd1)) state_next = ST_FIGHT;
            end
            ST_FIGHT: begin
                if (fight_result != WIN_NONE) state_next = ST_ROUND_END;
            end
            ST_ROUND_END: begin
                if (tc_done[TC_HOLD]) begin
                    state_next = (match_result != WIN_NONE) ? ST_MATCH_OVER : ST_CLEAR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and scoring state.
    always_comb begin
        clr_cnt_next      = (state_reg == ST_CLEAR) ? clr_cnt_reg + 1'b1 : '0;
        logic_clear_next  = (state_next == ST_CLEAR);
        p1_ctrl_g_next    = (state_next == ST_FIGHT) ? p1_ctrl : 3'b000;
        p2_ctrl_g_next    = (state_next == ST_FIGHT) ? p2_ctrl : 3'b000;
        countdown_next    = countdown_reg;
        score_char_next   = score_char_reg;
        score_squir_next  = score_squir_reg;
        round_cnt_next    = round_cnt_reg;
        round_winner_next = round_winner_reg;
        match_winner_next = match_winner_reg;

        if ((state_reg != ST_COUNTDOWN) && (state_next == ST_COUNTDOWN)) begin
            countdown_next = 2'(COUNT_STEPS);
        end else if (tc_done[TC_STEP]) begin
            countdown_next = countdown_reg - 2'd1;
        end

        if (((state_reg == ST_IDLE) || (state_reg == ST_MATCH_OVER)) && (state_next == ST_CLEAR)) begin
            score_char_next   = '0;
            score_squir_next  = '0;
            round_cnt_next    = '0;
            round_winner_next = WIN_NONE;
            match_winner_next = WIN_NONE;
        end

        if ((state_reg == ST_ROUND_END) && (state_next == ST_CLEAR)) begin
            round_winner_next = WIN_NONE;
        end

        if (fight_result != WIN_NONE) begin
            round_winner_next = fight_result;
            round_cnt_next    = round_cnt_reg + 1'b1;
            if ((fight_result == WIN_CHAR) && (score_char_reg != SCORE_W'(ROUNDS_TO_WIN))) begin
                score_char_next = score_char_reg + 1'b1;
            end
            if ((fight_result == WIN_SQUIR) && (score_squir_reg != SCORE_W'(ROUNDS_TO_WIN))) begin
                score_squir_next = score_squir_reg + 1'b1;
            end
        end

        if ((state_reg == ST_ROUND_END) && (state_next == ST_MATCH_OVER)) begin
            match_winner_next = match_result;
        end
    end

    // Output and scoring registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_cnt_reg      <= '0;
            logic_clear_reg  <= 1'b0;
            p1_ctrl_g_reg    <= 3'b000;
            p2_ctrl_g_reg    <= 3'b000;
            countdown_reg    <= 2'd0;
            score_char_reg   <= '0;
            score_squir_reg  <= '0;
            round_cnt_reg    <= '0;
            round_winner_reg <= WIN_NONE;
            match_winner_reg <= WIN_NONE;
        end else begin
            clr_cnt_reg      <= clr_cnt_next;
            logic_clear_reg  <= logic_clear_next;
            p1_ctrl_g_reg    <= p1_ctrl_g_next;
            p2_ctrl_g_reg    <= p2_ctrl_g_next;
            countdown_reg    <= countdown_next;
            score_char_reg   <= score_char_next;
            score_squir_reg  <= score_squir_next;
            round_cnt_reg    <= round_cnt_next;
            round_winner_reg <= round_winner_next;
            match_winner_reg <= match_winner_next;
        end
    end

    assign state        = state_reg;
    assign logic_clear  = logic_clear_reg;
    assign p1_ctrl_g    = p1_ctrl_g_reg;
    assign p2_ctrl_g    = p2_ctrl_g_reg;
    assign countdown    = countdown_reg;
    assign round_timer  = tc_count[TC_FGT];
    assign score_char   = score_char_reg;
    assign score_squir  = score_squir_reg;
    assign round_winner = round_winner_reg;
    assign match_winner = match_winner_reg;

endmodule

// File: tb/tb_pokemon_match_ctrl.sv
// Self-checking bench for pokemon_match_ctrl: a start-up vector table,
// hand-written round/match sequences and a randomized run, all checked
// every clk against a behavioural model of the match rules.
module tb_pokemon_match_ctrl;

    localparam int CLEAR_CYCLES = 4;
    localparam int COUNT_STEPS  = 3;
    localparam int TPS          = 20;
    localparam int ROUND_TICKS  = 600;
    localparam int END_TICKS    = 40;
    localparam int RTW          = 2;
    localparam int MAX_ROUNDS   = 5;

    logic       clk = 1'b0;
    logic       reset_n, tick, start_btn, char_alive, squir_alive;
    logic [6:0] health_char, health_squir;
    logic [2:0] p1_ctrl, p2_ctrl;
    logic [2:0] p1_ctrl_g, p2_ctrl_g, state, score_char, score_squir;
    logic       logic_clear;
    logic [1:0] countdown, round_winner, match_winner;
    logic [9:0] round_timer;

    always #5 clk = ~clk;

    pokemon_match_ctrl #(
        .CLEAR_CYCLES(CLEAR_CYCLES), .COUNT_STEPS(COUNT_STEPS), .TICKS_PER_STEP(TPS),
        .ROUND_TICKS(ROUND_TICKS), .END_TICKS(END_TICKS), .ROUNDS_TO_WIN(RTW),
        .MAX_ROUNDS(MAX_ROUNDS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_btn(start_btn),
        .char_alive(char_alive), .squir_alive(squir_alive),
        .health_char(health_char), .health_squir(health_squir),
        .p1_ctrl(p1_ctrl), .p2_ctrl(p2_ctrl), .p1_ctrl_g(p1_ctrl_g), .p2_ctrl_g(p2_ctrl_g),
        .logic_clear(logic_clear), .state(state), .countdown(countdown),
        .round_timer(round_timer), .score_char(score_char), .score_squir(score_squir),
        .round_winner(round_winner), .match_winner(match_winner)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    // Behavioural model: phase plus elapsed-event counts for each phase.
    int m_phase = 0, m_clear_seen = 0, m_cd_ticks = 0, m_timer = 0, m_end_ticks = 0;
    int m_sc = 0, m_ss = 0, m_rounds = 0, m_rw = 0, m_mw = 0;
    int m_p1g = 0, m_p2g = 0, m_cd = 0, m_clear = 0;

    typedef struct {
        int rst_n; int start; int tick; int reps;
        int exp_state; int exp_clear; int exp_cd; int exp_timer;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_step();
        int w;
        if (!reset_n) begin
            m_phase = 0; m_clear_seen = 0; m_cd_ticks = 0; m_timer = 0; m_end_ticks = 0;
            m_sc = 0; m_ss = 0; m_rounds = 0; m_rw = 0; m_mw = 0;
        end else begin
            case (m_phase)
                0, 5: if (start_btn) begin
                    m_phase = 1; m_clear_seen = 0;
                    m_sc = 0; m_ss = 0; m_rounds = 0; m_rw = 0; m_mw = 0;
                end
                1: begin
                    m_clear_seen++;
                    if (m_clear_seen == CLEAR_CYCLES) begin m_phase = 2; m_cd_ticks = 0; end
                end
                2: if (tick) begin
                    m_cd_ticks++;
                    if (m_cd_ticks == COUNT_STEPS * TPS) begin m_phase = 3; m_timer = ROUND_TICKS; end
                end
                3: begin
                    w = 0;
                    if (!char_alive && !squir_alive) w = 3;
                    else if (!squir_alive) w = 1;
                    else if (!char_alive) w = 2;
                    else if (tick && m_timer == 1)
                        w = (health_char > health_squir) ? 1 : (health_char < health_squir) ? 2 : 3;
                    if (tick && m_timer > 0) m_timer--;
                    if (w != 0) begin
                        m_rw = w; m_rounds++;
                        if (w == 1 && m_sc < RTW) m_sc++;
                        if (w == 2 && m_ss < RTW) m_ss++;
                        m_phase = 4; m_end_ticks = 0;
                    end
                end
                4: if (tick) begin
                    m_end_ticks++;
                    if (m_end_ticks == END_TICKS) begin
                        if (m_sc == RTW) begin m_phase = 5; m_mw = 1; end
                        else if (m_ss == RTW) begin m_phase = 5; m_mw = 2; end
                        else if (m_rounds == MAX_ROUNDS) begin
                            m_phase = 5;
                            m_mw = (m_sc > m_ss) ? 1 : (m_sc < m_ss) ? 2 : 3;
                        end else begin
                            m_phase = 1; m_clear_seen = 0; m_rw = 0;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
        m_clear = (m_phase == 1) ? 1 : 0;
        m_cd    = (m_phase == 2) ? COUNT_STEPS - m_cd_ticks / TPS : 0;
        m_p1g   = (m_phase == 3) ? int'(p1_ctrl) : 0;
        m_p2g   = (m_phase == 3) ? int'(p2_ctrl) : 0;
    endtask

    task automatic check_model();
        logic [31:0] got, exp;
        got = {state, logic_clear, p1_ctrl_g, p2_ctrl_g, countdown, round_timer,
               score_char, score_squir, round_winner, match_winner};
        exp = {3'(m_phase), 1'(m_clear), 3'(m_p1g), 3'(m_p2g), 2'(m_cd), 10'(m_timer),
               3'(m_sc), 3'(m_ss), 2'(m_rw), 2'(m_mw)};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_print < 20) begin
                n_print++;
                $display("FAIL model_cycle t=%0t: got %h, expected %h", $time, got, exp);
            end
        end
    endtask

    // One clk: model consumes the inputs sampled at the edge, outputs checked 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        for (int i = 0; i < budget && int'(state) != target; i++) cycle();
        check(name, int'(state), target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; tick = 1'b0; start_btn = 1'b0;
        char_alive = 1'b1; squir_alive = 1'b1;
        health_char = 7'd50; health_squir = 7'd50;
        p1_ctrl = 3'b000; p2_ctrl = 3'b000;

        //           rst start tick reps  state clear cd timer
        vecs[0]  = '{0,  0,    0,   1,    0,    0,    0, 0};
        vecs[1]  = '{1,  0,    1,   2,    0,    0,    0, 0};
        vecs[2]  = '{1,  1,    0,   1,    1,    1,    0, 0};
        vecs[3]  = '{1,  1,    1,   3,    1,    1,    0, 0};
        vecs[4]  = '{1,  0,    0,   1,    2,    0,    3, 0};
        vecs[5]  = '{1,  1,    1,   19,   2,    0,    3, 0};
        vecs[6]  = '{1,  0,    1,   1,    2,    0,    2, 0};
        vecs[7]  = '{1,  0,    0,   5,    2,    0,    2, 0};
        vecs[8]  = '{1,  0,    1,   20,   2,    0,    1, 0};
        vecs[9]  = '{1,  0,    1,   19,   2,    0,    1, 0};
        vecs[10] = '{1,  0,    1,   1,    3,    0,    0, 600};
        vecs[11] = '{1,  1,    1,   5,    3,    0,    0, 595};

        for (int i = 0; i < 12; i++) begin
            reset_n   = (vecs[i].rst_n != 0);
            start_btn = (vecs[i].start != 0);
            tick      = (vecs[i].tick != 0);
            repeat (vecs[i].reps) cycle();
            check($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
            check($sformatf("vec%0d_clear", i), int'(logic_clear), vecs[i].exp_clear);
            check($sformatf("vec%0d_countdown", i), int'(countdown), vecs[i].exp_cd);
            check($sformatf("vec%0d_timer", i), int'(round_timer), vecs[i].exp_timer);
            $display("[TB] vec %0d: state=%0d clear=%0d countdown=%0d timer=%0d",
                     i, state, logic_clear, countdown, round_timer);
        end
        start_btn = 1'b0; tick = 1'b0;

        // Round 1: gated control pass-through, then Squirtle faints.
        p1_ctrl = 3'b100;
        cycle();
        check("p1_ctrl_g_pass", int'(p1_ctrl_g), 4);
        check("p2_ctrl_g_idle", int'(p2_ctrl_g), 0);
        squir_alive = 1'b0;
        cycle();
        squir_alive = 1'b1;
        check("r1_state", int'(state), 4);
        check("r1_winner", int'(round_winner), 1);
        check("r1_score_char", int'(score_char), 1);
        check("r1_ctrl_forced", int'(p1_ctrl_g), 0);
        tick = 1'b1;
        repeat (END_TICKS - 1) cycle();
        check("r1_hold", int'(state), 4);
        cycle();
        check("r1_to_clear", int'(state), 1);
        check("r1_winner_cleared", int'(round_winner), 0);
        check("r1_clear_high", int'(logic_clear), 1);
        p1_ctrl = 3'b000;
        $display("[TB] round 1: winner=%0d score=%0d-%0d", round_winner, score_char, score_squir);

        // Round 2: double KO is a draw; flags stay low (stale) into the next CLEAR.
        wait_state(3, 200, "r2_reach_fight");
        char_alive = 1'b0; squir_alive = 1'b0;
        cycle();
        check("r2_winner_draw", int'(round_winner), 3);
        check("r2_score_char", int'(score_char), 1);
        check("r2_score_squir", int'(score_squir), 0);
        wait_state(1, 100, "r2_to_clear");
        wait_state(2, 20, "r2_stale_countdown");
        char_alive = 1'b1; squir_alive = 1'b1;
        wait_state(3, 200, "r3_reach_fight");
        repeat (3) cycle();
        check("r3_stale_ignored", int'(state), 3);

        // Round 3: timeout, Squirtle healthier.
        health_char = 7'd60; health_squir = 7'd80;
        wait_state(4, 700, "r3_timeout");
        check("r3_winner", int'(round_winner), 2);
        check("r3_score_squir", int'(score_squir), 1);
        check("r3_timer_zero", int'(round_timer), 0);
        $display("[TB] round 3: winner=%0d score=%0d-%0d", round_winner, score_char, score_squir);

        // Round 4: timeout with equal health is a draw.
        wait_state(3, 200, "r4_reach_fight");
        health_char = 7'd40; health_squir = 7'd40;
        wait_state(4, 700, "r4_timeout");
        check("r4_winner", int'(round_winner), 3);
        check("r4_score_char", int'(score_char), 1);
        check("r4_score_squir", int'(score_squir), 1);

        // Round 5: death on the final timer tick outranks the health verdict.
        wait_state(3, 200, "r5_reach_fight");
        health_char = 7'd10; health_squir = 7'd90;
        repeat (ROUND_TICKS - 1) cycle();
        check("r5_timer_one", int'(round_timer), 1);
        squir_alive = 1'b0;
        cycle();
        squir_alive = 1'b1;
        check("r5_winner_death", int'(round_winner), 1);
        check("r5_score_char", int'(score_char), 2);
        wait_state(5, 60, "match1_over");
        check("match1_winner", int'(match_winner), 1);
        repeat (10) cycle();
        check("match1_hold", int'(state), 5);
        $display("[TB] match 1: winner=%0d score=%0d-%0d", match_winner, score_char, score_squir);

        // Restart clears scores and winners.
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_score_char", int'(score_char), 0);
        check("restart_match_winner", int'(match_winner), 0);

        // Five straight draws hit the round cap.
        for (int r = 0; r < MAX_ROUNDS; r++) begin
            wait_state(3, 200, $sformatf("draw%0d_fight", r));
            char_alive = 1'b0; squir_alive = 1'b0;
            cycle();
            char_alive = 1'b1; squir_alive = 1'b1;
            check($sformatf("draw%0d_winner", r), int'(round_winner), 3);
            $display("[TB] draw round %0d: winner=%0d", r, round_winner);
        end
        wait_state(5, 60, "match2_over");
        check("match2_winner", int'(match_winner), 3);
        check("match2_score_squir", int'(score_squir), 0);

        // Reset in the middle of a fight.
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        wait_state(3, 200, "m3_fight");
        p1_ctrl = 3'b111;
        cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("rst_state", int'(state), 0);
        check("rst_ctrl_g", int'(p1_ctrl_g), 0);
        check("rst_timer", int'(round_timer), 0);
        check("rst_clear", int'(logic_clear), 0);
        check("rst_scores", int'({score_char, score_squir, round_winner, match_winner}), 0);

        // Randomized run against the model.
        for (int c = 0; c < 15000; c++) begin
            logic [2:0] prev_state;
            prev_state   = state;
            reset_n      = ($urandom_range(0, 2999) != 0);
            start_btn    = ($urandom_range(0, 49) == 0);
            tick         = ($urandom_range(0, 1) == 1);
            char_alive   = ($urandom_range(0, 299) != 0);
            squir_alive  = ($urandom_range(0, 299) != 0);
            health_char  = 7'($urandom_range(1, 3) * 30);
            health_squir = 7'($urandom_range(1, 3) * 30);
            p1_ctrl      = 3'($urandom);
            p2_ctrl      = 3'($urandom);
            cycle();
            if (state == 3'd4 && prev_state != 3'd4)
                $display("[TB] random round: winner=%0d score=%0d-%0d", round_winner, score_char, score_squir);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
